instruction_fetch: RTL and testbench

Fetch stage between the program counter and instruction decode of the 16-bit Hack CPU. It reads instructions from an instruction ROM at the address held by the PC, buffers fetched words in a small FIFO, and drives the PC's `inc`/`load` controls. Execute-stage jump requests redirect it, and it discards stale in-flight or buffered words.

---
 rtl/hack_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 48 ++++
 rtl/instruction_fetch.sv | 108 ++++++++++
 tb/tb_instruction_fetch.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU front end: default widths and the
// fetch-stage state encoding.
package hack_pkg;

    localparam int HACK_ADDR_W = 16;
    localparam int HACK_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        FLUSH = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer between the ROM interface and decode. Storage is
// unreset; only pointers and occupancy are cleared by reset or flush.
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem[wptr] <= wdata;
    end

    assign rdata = mem[rptr];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues one ROM read at a time from the PC, buffers returned
// words for decode, and steers the PC increment/load controls.
//
// state | meaning
// IDLE  | no request outstanding; issue from pc when buffer has room
// REQ   | live request outstanding; ack pushes the word and bumps the pc
// FLUSH | request outstanding but redirected; its ack is dropped
module instruction_fetch
    import hack_pkg::*;
#(
    parameter int ADDR_W = HACK_ADDR_W,
    parameter int DATA_W = HACK_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_target,
    input  logic              jump_valid,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_data,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [DATA_W-1:0] ins_data,
    output logic [ADDR_W-1:0] ins_addr
);

    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_t               state;
    logic [CW-1:0]              count;
    logic [CW-1:0]              count_next;
    logic                       push;
    logic                       pop;
    logic [DATA_W+ADDR_W-1:0]   head;

    assign pop        = ins_valid && ins_ready;
    assign push       = (state == REQ) && mem_ack && !jump_valid;
    assign count_next = count + CW'(push) - CW'(pop);

    // A redirect always wins over the increment; push already excludes jumps.
    assign pc_inc    = push;
    assign pc_load   = jump_valid && reset;
    assign pc_target = jump_target;

    assign ins_valid          = (count != '0);
    assign {ins_data, ins_addr} = head;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!jump_valid && count < CW'(DEPTH)) begin
                        state    <= REQ;
                        mem_req  <= 1'b1;
                        mem_addr <= pc;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        if (!jump_valid && count_next < CW'(DEPTH)) begin
                            mem_addr <= mem_addr + 1'b1;
                        end else begin
                            state   <= IDLE;
                            mem_req <= 1'b0;
                        end
                    end else if (jump_valid) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    fetch_fifo #(
        .WIDTH (DATA_W + ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (jump_valid),
        .wdata ({mem_data, mem_addr}),
        .rdata (head),
        .count (count)
    );

endmodule

// File: tb/tb_instruction_fetch.sv
// Randomised bench for instruction_fetch: a PC and ROM environment around the
// DUT, checked every cycle against a transaction-level model of the fetch rules.
module tb_instruction_fetch;

    localparam int DEPTH = 2;

    typedef struct { logic [15:0] data; logic [15:0] addr; } ent_t;
    typedef struct { int cyc; logic [15:0] addr; } pop_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic        pc_inc, pc_load;
    logic [15:0] pc_target;
    logic        jump_valid;
    logic [15:0] jump_target;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_data;
    logic        ins_valid, ins_ready;
    logic [15:0] ins_data, ins_addr;

    instruction_fetch #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .pc_target   (pc_target),
        .jump_valid  (jump_valid),
        .jump_target (jump_target),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_data    (mem_data),
        .ins_valid   (ins_valid),
        .ins_ready   (ins_ready),
        .ins_data    (ins_data),
        .ins_addr    (ins_addr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rel_cyc  = 0;

    // model state
    ent_t        q[$];
    pop_t        pops[$];
    logic        m_req = 1'b0;
    logic        stale = 1'b0;
    logic [15:0] m_addr = 16'h0;
    logic        in_reset = 1'b1;

    // environment state
    logic        samp_inc = 1'b0, samp_load = 1'b0;
    logic [15:0] samp_tgt = 16'h0;
    logic        prev_req = 1'b0, prev_ack = 1'b0, prev_jump = 1'b0;
    int          wait_cnt = 0;
    int          lat_min = 0, lat_max = 0, ready_pct = 100, jump_pct = 0;
    int          jump_on_ack = 0;
    logic        jump_on_rise = 1'b0;
    logic [15:0] forced_tgt = 16'h0;
    logic [15:0] pc_rel;

    function automatic logic [15:0] rom(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare DUT against the model, then advance the model across the edge.
    task automatic cmp_step();
        logic        exp_inc, pop, nreq, nstale;
        logic [15:0] new_pc;
        ent_t        e;
        pop_t        p;
        cyc++;
        if (!reset) begin
            chk("rst_mem_req",   32'(mem_req),   32'd0);
            chk("rst_mem_addr",  32'(mem_addr),  32'd0);
            chk("rst_ins_valid", 32'(ins_valid), 32'd0);
            chk("rst_pc_inc",    32'(pc_inc),    32'd0);
            chk("rst_pc_load",   32'(pc_load),   32'd0);
            q.delete();
            m_req = 1'b0; stale = 1'b0; in_reset = 1'b1;
            samp_inc = 1'b0; samp_load = 1'b0;
            return;
        end
        if (in_reset) begin
            rel_cyc  = cyc;
            in_reset = 1'b0;
        end
        chk("ins_valid", 32'(ins_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("ins_data", 32'(ins_data), 32'(q[0].data));
            chk("ins_addr", 32'(ins_addr), 32'(q[0].addr));
        end
        chk("mem_req", 32'(mem_req), 32'(m_req));
        if (m_req) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
        chk("pc_load", 32'(pc_load), 32'(jump_valid));
        if (jump_valid) chk("pc_target", 32'(pc_target), 32'(jump_target));
        exp_inc = m_req && mem_ack && !jump_valid && !stale;
        chk("pc_inc", 32'(pc_inc), 32'(exp_inc));

        pop    = (q.size() != 0) && ins_ready;
        new_pc = jump_valid ? jump_target : (exp_inc ? pc + 16'd1 : pc);
        if (m_req)
            nreq = mem_ack ? (exp_inc && (q.size() - int'(pop) + 1 < DEPTH)) : 1'b1;
        else
            nreq = !jump_valid && (q.size() < DEPTH);
        nstale = m_req && !mem_ack && (stale || jump_valid);
        if (nreq && !(m_req && !mem_ack)) m_addr = new_pc;
        if (pop) begin
            p.cyc = cyc; p.addr = q[0].addr;
            pops.push_back(p);
        end
        if (jump_valid) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (exp_inc) begin
                e.data = rom(pc); e.addr = pc;
                q.push_back(e);
            end
        end
        m_req = nreq;
        stale = nstale;
        samp_inc  = pc_inc;
        samp_load = pc_load;
        samp_tgt  = pc_target;
    endtask

    task automatic drive();
        logic rise;
        if (samp_load) pc = samp_tgt;
        else if (samp_inc) pc = pc + 16'd1;
        jump_valid = 1'b0;
        if (!reset) begin
            mem_ack = 1'b0; prev_req = 1'b0; prev_ack = 1'b0; prev_jump = 1'b0; wait_cnt = 0;
        end else begin
            rise = mem_req && !prev_req;
            if (mem_req && (rise || prev_ack)) begin
                wait_cnt = $urandom_range(lat_max, lat_min);
                if (rise && wait_cnt == 0) wait_cnt = 1;
            end
            mem_ack = mem_req && (wait_cnt == 0);
            if (mem_req && wait_cnt != 0) wait_cnt--;
            prev_req = mem_req;
            prev_ack = mem_ack;
            if (jump_on_rise && rise) begin
                jump_valid = 1'b1; jump_target = forced_tgt; jump_on_rise = 1'b0;
            end else if (jump_on_ack != 0 && mem_ack) begin
                jump_on_ack--;
                if (jump_on_ack == 0) begin
                    jump_valid = 1'b1; jump_target = forced_tgt;
                end
            end else if (!prev_jump && $urandom_range(99, 0) < jump_pct) begin
                jump_valid = 1'b1; jump_target = 16'($urandom);
            end
            prev_jump = jump_valid;
        end
        mem_data  = mem_ack ? rom(mem_addr) : 16'($urandom);
        ins_ready = ($urandom_range(99, 0) < ready_pct);
    endtask

    task automatic step();
        @(negedge clk);
        cmp_step();
        @(posedge clk);
        #1;
        drive();
    endtask

    task automatic start(input logic [15:0] pc0, input int lmin, input int lmax, input int rdy);
        reset = 1'b0;
        jump_valid = 1'b0; mem_ack = 1'b0;
        pc = pc0;
        lat_min = lmin; lat_max = lmax; ready_pct = rdy; jump_pct = 0;
        step();
        step();
        reset = 1'b1;
        pops.delete();
    endtask

    task automatic run_until_pops(input int n, input int budget);
        for (int i = 0; i < budget && pops.size() < n; i++) step();
        chk("pop_timeout", 32'(pops.size() >= n), 32'd1);
    endtask

    initial begin
        reset = 1'b1; pc = 16'h0; jump_valid = 1'b0; jump_target = 16'h0;
        mem_ack = 1'b0; mem_data = 16'h0; ins_ready = 1'b0;
        #1 reset = 1'b0;

        // streaming from 0, ack every cycle, decode always ready
        start(16'h0000, 0, 0, 100);
        run_until_pops(4, 40);
        if (pops.size() >= 4) begin
            for (int i = 0; i < 4; i++) chk("d1_addr", 32'(pops[i].addr), 32'(i));
            chk("d1_first_cycle", pops[0].cyc, rel_cyc + 3);
            chk("d1_back_to_back", pops[3].cyc, pops[0].cyc + 3);
        end

        // decode stalled: buffer fills, requests stop, then drain and resume
        start(16'h0000, 0, 0, 0);
        repeat (8) step();
        #2;
        chk("d2_valid", 32'(ins_valid), 32'd1);
        chk("d2_head", 32'(ins_addr), 32'h0000);
        chk("d2_req_stopped", 32'(mem_req), 32'd0);
        ready_pct = 100;
        run_until_pops(3, 40);
        if (pops.size() >= 3)
            for (int i = 0; i < 3; i++) chk("d2_drain_addr", 32'(pops[i].addr), 32'(i));

        // redirect while a request is outstanding; its late ack is dropped
        jump_on_rise = 1'b1; forced_tgt = 16'h0100;
        start(16'h0000, 3, 3, 100);
        run_until_pops(1, 60);
        if (pops.size() >= 1) chk("d3_target_addr", 32'(pops[0].addr), 32'h0100);

        // redirect in the same cycle as an ack, with a word buffered
        jump_on_ack = 2; forced_tgt = 16'h0200;
        start(16'h0000, 2, 2, 0);
        for (int i = 0; i < 40 && !(mem_ack && jump_valid); i++) step();
        #2;
        chk("d4_jump_with_ack", 32'(mem_ack && jump_valid), 32'd1);
        chk("d4_pc_load", 32'(pc_load), 32'd1);
        chk("d4_pc_inc", 32'(pc_inc), 32'd0);
        chk("d4_buffered", 32'(ins_valid), 32'd1);
        step();
        #2;
        chk("d4_emptied", 32'(ins_valid), 32'd0);

        // address wrap
        start(16'hFFFE, 0, 0, 100);
        run_until_pops(3, 40);
        if (pops.size() >= 3) begin
            chk("d5_addr0", 32'(pops[0].addr), 32'hFFFE);
            chk("d5_addr1", 32'(pops[1].addr), 32'hFFFF);
            chk("d5_addr2", 32'(pops[2].addr), 32'h0000);
        end

        // reset during an ack cycle with a word buffered
        start(16'h1234, 3, 3, 0);
        for (int i = 0; i < 60 && !(mem_ack && ins_valid); i++) step();
        #1;
        chk("d6_setup", 32'(mem_ack && ins_valid && mem_req), 32'd1);
        chk("d6_inc_before", 32'(pc_inc), 32'd1);
        reset = 1'b0;
        #1;
        chk("d6_req_cleared", 32'(mem_req), 32'd0);
        chk("d6_valid_cleared", 32'(ins_valid), 32'd0);
        chk("d6_inc_cleared", 32'(pc_inc), 32'd0);
        step();
        step();
        pc_rel = pc;
        reset = 1'b1; ready_pct = 100; pops.delete();
        chk("d6_pc_kept", 32'(pc_rel), 32'h1235);
        run_until_pops(1, 40);
        if (pops.size() >= 1) chk("d6_restart_addr", 32'(pops[0].addr), 32'(pc_rel));

        // randomised phases
        start(16'($urandom), 0, 0, 100); jump_pct = 0;  repeat (1500) step();
        start(16'($urandom), 0, 3, 50);  jump_pct = 5;  repeat (3000) step();
        start(16'($urandom), 0, 2, 85);  jump_pct = 15; repeat (3000) step();
        start(16'($urandom), 1, 4, 30);  jump_pct = 8;  repeat (3000) step();
        start(16'($urandom), 0, 1, 100); jump_pct = 25; repeat (2000) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
